// File: rtl/apb_uart_rx_fifo_if.sv
// APB slave bus bundle for the UART receiver: address/control from the master,
// combinational read data and error back from the slave.
interface apb_uart_rx_fifo_if;
    logic       psel;
    logic [2:0] paddr;
    logic       penable;
    logic       pwrite;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pslverr;

    modport master (output psel, paddr, penable, pwrite, pwdata, input prdata, pslverr);
    modport slave  (input psel, paddr, penable, pwrite, pwdata, output prdata, pslverr);
endinterface

// File: rtl/apb_uart_rx_fifo.sv
// APB-controlled UART receiver with receive FIFO, optional parity and sticky
// framing/overrun/parity error flags.
module apb_uart_rx_fifo #(
    parameter int unsigned FIFO_DEPTH       = 8,
    parameter int unsigned RESET_BIT_PERIOD = 10,
    parameter int unsigned RESET_DATA_SIZE  = 8
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  serial_in,
    apb_uart_rx_fifo_if.slave     apb_s
);
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BITP_W = 14;

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} rx_state_e;

    rx_state_e          state_q, state_d;
    logic [BITP_W-1:0]  bitp_q, bitp_d, sh_bitp_q, sh_bitp_d, timer_q, timer_d;
    logic [3:0]         dsize_q, dsize_d, sh_dsize_q, sh_dsize_d;
    logic [1:0]         ctrl_q, ctrl_d, sh_ctrl_q, sh_ctrl_d;
    logic [2:0]         err_q, err_d, new_err, bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               par_acc_q, par_acc_d, par_bad_q, par_bad_d;
    logic               sync1_q, sync2_q, prev_q;
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               bus_err, wr_en, rd_en, pop, err_clr, push, tick, fall, full;

    // APB decode and combinational read mux
    always_comb begin
        bus_err = (apb_s.paddr == 3'd7) ||
                  (apb_s.pwrite && (apb_s.paddr == 3'd0 || apb_s.paddr == 3'd1 || apb_s.paddr == 3'd6));
        wr_en   = apb_s.psel && apb_s.penable && apb_s.pwrite && !bus_err;
        rd_en   = apb_s.psel && apb_s.penable && !apb_s.pwrite && !bus_err;
        pop     = rd_en && (apb_s.paddr == 3'd6) && (count_q != '0);
        err_clr = rd_en && (apb_s.paddr == 3'd1);
        apb_s.pslverr = apb_s.psel && bus_err;
        apb_s.prdata  = 8'h00;
        if (apb_s.psel && !bus_err) begin
            unique case (apb_s.paddr)
                3'd0:    apb_s.prdata = {7'(count_q), count_q != '0};
                3'd1:    apb_s.prdata = {5'b0, err_q};
                3'd2:    apb_s.prdata = bitp_q[7:0];
                3'd3:    apb_s.prdata = {2'b0, bitp_q[13:8]};
                3'd4:    apb_s.prdata = {4'b0, dsize_q};
                3'd5:    apb_s.prdata = {6'b0, ctrl_q};
                3'd6:    apb_s.prdata = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
                default: apb_s.prdata = 8'h00;
            endcase
        end
    end

    // Receiver next state; the frame decision is made on the stop-bit sample
    always_comb begin
        state_d    = state_q;
        timer_d    = (timer_q != '0) ? timer_q - BITP_W'(1) : timer_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        par_acc_d  = par_acc_q;
        par_bad_d  = par_bad_q;
        sh_bitp_d  = sh_bitp_q;
        sh_dsize_d = sh_dsize_q;
        sh_ctrl_d  = sh_ctrl_q;
        new_err    = 3'b000;
        push       = 1'b0;
        tick       = (timer_q <= BITP_W'(1));
        fall       = prev_q && !sync2_q;
        full       = (count_q == CNT_W'(FIFO_DEPTH)) && !pop;
        unique case (state_q)
            ST_IDLE: if (fall) begin
                sh_bitp_d  = bitp_q;
                sh_dsize_d = dsize_q;
                sh_ctrl_d  = ctrl_q;
                timer_d    = bitp_q >> 1;
                shift_d    = 8'h00;
                par_acc_d  = 1'b0;
                par_bad_d  = 1'b0;
                bit_idx_d  = 3'd0;
                state_d    = ST_START;
            end
            ST_START: if (tick) begin
                if (sync2_q) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d   = sh_bitp_q;
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: if (tick) begin
                shift_d[bit_idx_q] = sync2_q;
                par_acc_d = par_acc_q ^ sync2_q;
                timer_d   = sh_bitp_q;
                if (bit_idx_q == 3'(sh_dsize_q - 4'd1)) begin
                    state_d = sh_ctrl_q[0] ? ST_PARITY : ST_STOP;
                end else begin
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            ST_PARITY: if (tick) begin
                par_bad_d = par_acc_q ^ sync2_q ^ sh_ctrl_q[1];
                timer_d   = sh_bitp_q;
                state_d   = ST_STOP;
            end
            ST_STOP: if (tick) begin
                state_d    = ST_IDLE;
                new_err[0] = !sync2_q;
                new_err[2] = par_bad_q;
                if (sync2_q && !par_bad_q) begin
                    if (full) new_err[1] = 1'b1;
                    else      push       = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Config registers, sticky flags and FIFO bookkeeping
    always_comb begin
        bitp_d   = bitp_q;
        dsize_d  = dsize_q;
        ctrl_d   = ctrl_q;
        if (wr_en) begin
            unique case (apb_s.paddr)
                3'd2:    bitp_d[7:0]  = apb_s.pwdata;
                3'd3:    bitp_d[13:8] = apb_s.pwdata[5:0];
                3'd4:    if (apb_s.pwdata[3:0] >= 4'd5 && apb_s.pwdata[3:0] <= 4'd8)
                             dsize_d = apb_s.pwdata[3:0];
                3'd5:    ctrl_d = apb_s.pwdata[1:0];
                default: ;
            endcase
        end
        err_d    = (err_clr ? 3'b000 : err_q) | new_err;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q    <= ST_IDLE;
            bitp_q     <= BITP_W'(RESET_BIT_PERIOD);
            dsize_q    <= 4'(RESET_DATA_SIZE);
            ctrl_q     <= 2'b00;
            err_q      <= 3'b000;
            sh_bitp_q  <= '0;
            sh_dsize_q <= '0;
            sh_ctrl_q  <= '0;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            par_acc_q  <= 1'b0;
            par_bad_q  <= 1'b0;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= 8'h00;
        end else begin
            state_q    <= state_d;
            bitp_q     <= bitp_d;
            dsize_q    <= dsize_d;
            ctrl_q     <= ctrl_d;
            err_q      <= err_d;
            sh_bitp_q  <= sh_bitp_d;
            sh_dsize_q <= sh_dsize_d;
            sh_ctrl_q  <= sh_ctrl_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            par_acc_q  <= par_acc_d;
            par_bad_q  <= par_bad_d;
            sync1_q    <= serial_in;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            if (push) mem_q[wr_ptr_q] <= shift_q;
        end
    end
endmodule

// File: tb/tb_apb_uart_rx_fifo.sv
// Directed bench for apb_uart_rx_fifo: register access, reception, parity,
// framing, overrun/wrap, bus errors, glitch rejection and mid-frame events.
module tb_apb_uart_rx_fifo;
    localparam int BIT = 100;

    logic clk = 1'b0;
    logic n_rst = 1'b1;
    logic serial_in = 1'b1;
    int   checks = 0;
    int   failures = 0;

    apb_uart_rx_fifo_if bus ();

    apb_uart_rx_fifo #(.FIFO_DEPTH(8), .RESET_BIT_PERIOD(10), .RESET_DATA_SIZE(8)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .serial_in (serial_in),
        .apb_s     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic apb_xfer(input logic wr, input logic [2:0] a, input logic [7:0] wd,
                            output logic [7:0] rd, output logic err);
        bus.psel = 1'b1; bus.paddr = a; bus.pwrite = wr; bus.pwdata = wd; bus.penable = 1'b0;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        #1;
        rd = bus.prdata; err = bus.pslverr;
        @(posedge clk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
        logic [7:0] d; logic e;
        apb_xfer(1'b0, a, 8'h00, d, e);
        check(tag, d, exp);
        check({tag, "_slverr"}, {7'b0, e}, 8'h00);
    endtask

    task automatic wr_chk(input string tag, input logic [2:0] a, input logic [7:0] wd, input logic exp_err);
        logic [7:0] d; logic e;
        apb_xfer(1'b1, a, wd, d, e);
        check({tag, "_slverr"}, {7'b0, e}, {7'b0, exp_err});
    endtask

    task automatic uart_bit(input logic v);
        serial_in = v;
        repeat (BIT) @(posedge clk);
    endtask

    task automatic uart_send(input logic [7:0] d, input int nbits, input logic par_en,
                             input logic par_bit, input logic stop_bit);
        uart_bit(1'b0);
        for (int i = 0; i < nbits; i++) uart_bit(d[i]);
        if (par_en) uart_bit(par_bit);
        uart_bit(stop_bit);
        serial_in = 1'b1;
        repeat (20) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] d; logic e;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 3'd0; bus.pwdata = 8'h00;
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b0;
        #1;
        check("rst_prdata", bus.prdata, 8'h00);
        check("rst_pslverr", {7'b0, bus.pslverr}, 8'h00);
        rd_chk("rst_bitp_lo", 3'd2, 8'h0A);
        rd_chk("rst_bitp_hi", 3'd3, 8'h00);
        rd_chk("rst_dsize", 3'd4, 8'h08);
        rd_chk("rst_ctrl", 3'd5, 8'h00);
        rd_chk("rst_status", 3'd0, 8'h00);
        rd_chk("rst_error", 3'd1, 8'h00);

        wr_chk("wr_bitp_lo", 3'd2, 8'h64, 1'b0);
        wr_chk("wr_bitp_hi", 3'd3, 8'h00, 1'b0);
        wr_chk("wr_dsize5", 3'd4, 8'h05, 1'b0);
        rd_chk("rb_bitp_lo", 3'd2, 8'h64);
        rd_chk("rb_bitp_hi", 3'd3, 8'h00);
        rd_chk("rb_dsize5", 3'd4, 8'h05);
        wr_chk("wr_dsize8", 3'd4, 8'h08, 1'b0);

        // basic receive, with erroring writes that must not disturb the FIFO
        uart_send(8'hA5, 8, 1'b0, 1'b0, 1'b1);
        rd_chk("basic_status", 3'd0, 8'h03);
        wr_chk("bad_wr_status", 3'd0, 8'hFF, 1'b1);
        wr_chk("bad_wr_rxdata", 3'd6, 8'hFF, 1'b1);
        rd_chk("basic_status2", 3'd0, 8'h03);
        rd_chk("basic_rxdata", 3'd6, 8'hA5);
        rd_chk("basic_status_empty", 3'd0, 8'h00);
        rd_chk("empty_rxdata", 3'd6, 8'h00);

        // unmapped address and illegal data size
        apb_xfer(1'b0, 3'd7, 8'h00, d, e);
        check("addr7_rd_data", d, 8'h00);
        check("addr7_rd_slverr", {7'b0, e}, 8'h01);
        wr_chk("addr7_wr", 3'd7, 8'hFF, 1'b1);
        wr_chk("dsize_illegal", 3'd4, 8'h03, 1'b0);
        rd_chk("dsize_unchanged", 3'd4, 8'h08);

        // odd parity, 7 data bits
        wr_chk("wr_dsize7", 3'd4, 8'h07, 1'b0);
        wr_chk("wr_ctrl_odd", 3'd5, 8'h03, 1'b0);
        uart_send(8'h35, 7, 1'b1, 1'b1, 1'b1);
        rd_chk("par_ok_status", 3'd0, 8'h03);
        rd_chk("par_ok_rxdata", 3'd6, 8'h35);
        uart_send(8'h35, 7, 1'b1, 1'b0, 1'b1);
        rd_chk("par_bad_error", 3'd1, 8'h04);
        rd_chk("par_bad_error_clr", 3'd1, 8'h00);
        rd_chk("par_bad_status", 3'd0, 8'h00);
        uart_send(8'h35, 7, 1'b1, 1'b1, 1'b0);
        wr_chk("bad_wr_error", 3'd1, 8'hFF, 1'b1);
        rd_chk("frame_error", 3'd1, 8'h01);
        rd_chk("frame_status", 3'd0, 8'h00);
        wr_chk("wr_ctrl_off", 3'd5, 8'h00, 1'b0);
        wr_chk("wr_dsize8b", 3'd4, 8'h08, 1'b0);

        // short low pulse must be rejected as a glitch
        serial_in = 1'b0;
        repeat (30) @(posedge clk);
        serial_in = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        rd_chk("glitch_status", 3'd0, 8'h00);
        rd_chk("glitch_error", 3'd1, 8'h00);

        // overrun on the ninth byte, then drain and wrap
        for (int i = 1; i <= 9; i++) uart_send(8'(i), 8, 1'b0, 1'b0, 1'b1);
        rd_chk("ovr_status", 3'd0, 8'h11);
        rd_chk("ovr_error", 3'd1, 8'h02);
        for (int i = 1; i <= 8; i++) rd_chk($sformatf("ovr_pop%0d", i), 3'd6, 8'(i));
        rd_chk("ovr_drained", 3'd0, 8'h00);
        uart_send(8'h0A, 8, 1'b0, 1'b0, 1'b1);
        uart_send(8'h0B, 8, 1'b0, 1'b0, 1'b1);
        rd_chk("wrap_status", 3'd0, 8'h05);
        rd_chk("wrap_pop0a", 3'd6, 8'h0A);
        rd_chk("wrap_pop0b", 3'd6, 8'h0B);

        // bit period rewritten mid-frame must not affect the frame in flight
        fork
            uart_send(8'h5A, 8, 1'b0, 1'b0, 1'b1);
            begin
                repeat (350) @(posedge clk);
                #1 wr_chk("mid_wr_bitp", 3'd2, 8'h32, 1'b0);
            end
        join
        rd_chk("mid_rxdata", 3'd6, 8'h5A);
        rd_chk("mid_bitp", 3'd2, 8'h32);
        wr_chk("restore_bitp", 3'd2, 8'h64, 1'b0);

        // reset mid-frame: FIFO emptied, flags cleared, frame abandoned
        uart_send(8'h33, 8, 1'b0, 1'b0, 1'b1);
        rd_chk("pre_rst_status", 3'd0, 8'h03);
        fork
            uart_send(8'hFF, 8, 1'b0, 1'b0, 1'b1);
            begin
                repeat (400) @(posedge clk);
                #1 n_rst = 1'b1;
                repeat (2) @(posedge clk);
                #1 n_rst = 1'b0;
            end
        join
        rd_chk("midrst_status", 3'd0, 8'h00);
        rd_chk("midrst_error", 3'd1, 8'h00);
        rd_chk("midrst_bitp", 3'd2, 8'h0A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/apb_uart_rx_fifo.md
Name: apb_uart_rx_fifo

Overview:
- APB-slave-controlled UART receiver; successor to the single-byte receiver block.
- Adds a parameterised receive FIFO, optional even/odd parity, sticky framing/overrun/parity error flags and a FIFO occupancy count.
- Sits on the peripheral APB bus; serial_in comes from the board pin.
- One clock; reset is synchronous and active-high.

Parameters:
- FIFO_DEPTH, 8: receive FIFO entries; power of 2, range 2..64.
- RESET_BIT_PERIOD, 10: bit-period register reset value, in clk cycles; 14 bits.
- RESET_DATA_SIZE, 8: data-size register reset value; legal 5..8.

Ports:
- clk  input  1  system clock, rising edge
- n_rst  input  1  synchronous, active-high reset: 1 at a clk edge resets the block
- serial_in  input  1  asynchronous UART line, idle high
- psel  input  1  APB select
- paddr  input  3  APB address
- penable  input  1  APB enable phase
- pwrite  input  1  1 = write, 0 = read
- pwdata  input  8  write data
- prdata  output  8  read data
- pslverr  output  1  transfer error

Behaviour:
- Register map, 8-bit:
  - 0 STATUS (RO): bit0 = FIFO not empty; [7:1] = entry count.
  - 1 ERROR (RO): bit0 framing, bit1 overrun, bit2 parity; sticky.
  - 2 BITP_LO (RW): bit period [7:0].
  - 3 BITP_HI (RW): [5:0] = bit period [13:8]; [7:6] read 0.
  - 4 DSIZE (RW): [3:0] data size; [7:4] read 0.
  - 5 CTRL (RW): bit0 parity enable, bit1 odd parity.
  - 6 RXDATA (RO): FIFO head, zero-extended.
  - 7: unmapped.
- APB access:
  - prdata and pslverr are combinational, valid whenever psel=1.
  - State effects (register write, FIFO pop, error clear) occur only at the clk edge where psel & penable = 1.
  - prdata = 0 when psel=0 or on error.
  - pslverr = 1 for any access to addr 7, or a write to addr 0, 1 or 6. An erroring write changes nothing.
  - A write of 0..4 or 9..15 to DSIZE is ignored and still completes with pslverr=0. The value read back is unchanged.
  - A bit-period write yielding a value < 4 is stored as written. Reception behaviour for such values is undefined; the bench must not rely on it.
- Reset: every register and state returns to its reset value.
  - BITP = RESET_BIT_PERIOD, DSIZE = RESET_DATA_SIZE, CTRL = 0.
  - FIFO empty; error flags 0; receiver in IDLE; synchroniser loaded with 1s.
  - prdata = 0, pslverr = 0.
  - Reset mid-frame abandons the frame; no partial entry is pushed.
- Input synchronisation: serial_in passes through a 2-flop synchroniser. Edge detection compares the synchronised value with its prior-cycle value.
- Receiver FSM:
  - IDLE: on a synchronised 1→0 edge, latch BITP, DSIZE and CTRL into shadow copies (config writes mid-frame do not affect the current frame). Load timer = BITP/2 (floor), go to START.
  - START: at timer expiry, sample. If 1, it is a glitch: return to IDLE with no flag. If 0, go to DATA with timer = BITP and bit index = 0.
  - DATA: every BITP cycles, sample into the shift register, LSB first. After DSIZE bits, go to PARITY if parity is enabled, else STOP.
  - PARITY: sample the parity bit. Even parity: XOR of data and parity bit must be 0. Odd parity: it must be 1.
  - STOP: sample the stop bit. In this sampling cycle, decide the frame:
    - stop = 0: framing flag set; frame discarded.
    - parity mismatch: parity flag set; frame discarded.
    - else FIFO full: overrun flag set; frame discarded, FIFO contents untouched.
    - else: push data zero-extended to 8 bits.
    - In every case the FSM returns to IDLE the next cycle and is ready for a new start edge mid-stop-bit.
  - If both framing and parity fail, both flags set.
- FIFO:
  - Circular buffer with wrap-around pointers and an explicit count of 0..FIFO_DEPTH.
  - A pushed byte is visible in STATUS and RXDATA on the cycle after the push edge.
  - Reading RXDATA returns the head and pops it at the access edge.
  - Reading RXDATA when empty returns 0x00, does not pop, pslverr = 0.
  - Push and pop on the same edge: both occur, count unchanged. When full, a pop plus a simultaneous push is accepted with no overrun.
- Error flags:
  - A read of ERROR returns the flags and clears them at the access edge.
  - A new error set in the same cycle as the clear wins; that flag remains 1.
- Latency: the push occurs at the edge of the stop-bit sample, nominally start edge + 2 sync cycles + BITP/2 + (DSIZE + parity + 1)·BITP cycles.

Test Plan:
- Reset and readback:
  - Assert n_rst=1 for 2 cycles, then release. Reads must return: addr2 = 0x0A, addr3 = 0x00, addr4 = 0x08, addr5 = 0x00, addr0 = 0x00, addr1 = 0x00.
  - Write BITP = 100 (0x64/0x00) and DSIZE = 5; the same values must read back.
- Basic receive: BITP = 100, DSIZE = 8, no parity. Send 0xA5 with 1000 ns bits.
  - addr0 = 0x03, addr6 = 0xA5, then addr0 = 0x00.
  - A further addr6 read returns 0x00 with no error.
- Parity and framing:
  - DSIZE = 7, odd parity. Send 0x35 with parity bit 1: accepted, RXDATA = 0x35.
  - Send 0x35 with parity bit 0: ERROR = 0x04, and a second ERROR read = 0x00.
  - Send a frame with stop bit 0: ERROR = 0x01, FIFO empty.
- Overrun and wrap:
  - FIFO_DEPTH = 8. Send 9 bytes 0x01..0x09 with no reads. STATUS = 0x11, ERROR = 0x02.
  - Pops return 0x01..0x08 in order.
  - Then send 0x0A and 0x0B; pointers wrap and the pops return 0x0A, 0x0B.
- Bus errors:
  - Read and write of addr7: pslverr = 1, prdata = 0.
  - Write 0xFF to addr0, addr1 and addr6: pslverr = 1, no state change.
  - Write 3 to DSIZE: pslverr = 0, DSIZE still reads 8.
- Glitch and mid-frame: a 30-cycle low pulse with BITP = 100 produces no push and no flag.
  - Rewriting BITP to 50 mid-frame does not corrupt the current byte.
  - Asserting n_rst mid-frame leaves the FIFO empty with all flags 0.
